pc_target_unit: RTL

PC_TARGET_UNIT -- requirements
Module: pc_target_unit

---
 rtl/pc_target_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pc_target_unit.sv
// Next-PC selection with a circular return-address stack that predicts and
// checks JR-return targets; the PC itself always follows the selected target.
module pc_target_unit #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Stall,
    input  logic [2:0]                   Op,
    input  logic [31:0]                  Instruction,
    input  logic [ADDR_W-1:0]            RegTarget,
    output logic [ADDR_W-1:0]            PC,
    output logic [ADDR_W-1:0]            PCPlus4,
    output logic [ADDR_W-1:0]            JumpAddress,
    output logic [$clog2(RAS_DEPTH):0]   RASCount,
    output logic                         RASMismatch,
    output logic                         RASOverflow,
    output logic                         AlignFault,
    output logic [7:0]                   MismatchCount
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    typedef enum logic [2:0] {
        OP_SEQ  = 3'b000,
        OP_BR   = 3'b001,
        OP_J    = 3'b010,
        OP_JAL  = 3'b011,
        OP_JR   = 3'b100,
        OP_RET  = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } op_e;

    op_e               op;
    logic [ADDR_W-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]     sp;
    logic [PW-1:0]     sp_m1;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] reg_aligned;
    logic [ADDR_W-1:0] next_pc;
    logic              full;
    logic              ret_miss;
    logic              advance;
    logic              unused_instr;

    assign op            = op_e'(Op);
    assign advance       = !Reset && !Stall;
    assign PCPlus4       = PC + ADDR_W'(4);
    assign JumpAddress   = {PCPlus4[ADDR_W-1:28], Instruction[25:0], 2'b00};
    assign branch_target = PCPlus4 + {{(ADDR_W-18){Instruction[15]}}, Instruction[15:0], 2'b00};
    assign reg_aligned   = {RegTarget[ADDR_W-1:2], 2'b00};
    assign full          = (RASCount == FULL);
    assign sp_m1         = sp - PW'(1);
    // sp points at the next free slot; the top entry sits one below it.
    assign ret_miss      = (RASCount == '0) || (ras[sp_m1] != reg_aligned);
    assign unused_instr  = ^Instruction[31:26];

    always_comb begin
        next_pc = PCPlus4;
        case (op)
            OP_BR:          next_pc = branch_target;
            OP_J, OP_JAL:   next_pc = JumpAddress;
            OP_JR, OP_RET:  next_pc = reg_aligned;
            default:        next_pc = PCPlus4;
        endcase
    end

    // Stack storage carries no reset; a full push lands on the oldest slot.
    always_ff @(posedge Clk) begin
        if (advance && op == OP_JAL)
            ras[sp] <= PCPlus4;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            PC            <= RESET_PC;
            sp            <= '0;
            RASCount      <= '0;
            RASMismatch   <= 1'b0;
            RASOverflow   <= 1'b0;
            AlignFault    <= 1'b0;
            MismatchCount <= '0;
        end else if (Stall) begin
            RASMismatch <= 1'b0;
            AlignFault  <= 1'b0;
        end else begin
            PC          <= next_pc;
            RASMismatch <= 1'b0;
            AlignFault  <= 1'b0;
            case (op)
                OP_JAL: begin
                    sp <= sp + PW'(1);
                    if (full)
                        RASOverflow <= 1'b1;
                    else
                        RASCount <= RASCount + CW'(1);
                end
                OP_JR: begin
                    AlignFault <= |RegTarget[1:0];
                end
                OP_RET: begin
                    AlignFault  <= |RegTarget[1:0];
                    RASMismatch <= ret_miss;
                    if (RASCount != '0) begin
                        sp       <= sp_m1;
                        RASCount <= RASCount - CW'(1);
                    end
                    if (ret_miss && MismatchCount != 8'hFF)
                        MismatchCount <= MismatchCount + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
